// File: rtl/integer_issue_select_if.sv
// integer_issue_select_if: issue-queue read port, allocation/wake-up reports and ALU issue register bundle.
interface integer_issue_select_if #(
  parameter int INT_QUEUE_SIZE = 8,
  parameter int INT_QUEUE_SIZE_INDEX = 3,
  parameter int PHYS_REG_NUM_INDEX = 6,
  parameter int ACTIVE_LIST_SIZE_INDEX = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ALU_CTL_WIDTH = 4
);
  logic [INT_QUEUE_SIZE-1:0] q_entry_available_bit, q_ready_src1, q_ready_src2;
  logic [INT_QUEUE_SIZE-1:0] q_is_branch, q_prediction, q_uses_rs, q_uses_rt, q_uses_immediate;
  logic [INT_QUEUE_SIZE-1:0][PHYS_REG_NUM_INDEX-1:0] q_src1, q_src2;
  logic [INT_QUEUE_SIZE-1:0][DATA_WIDTH-1:0] q_immediate;
  logic [INT_QUEUE_SIZE-1:0][ALU_CTL_WIDTH-1:0] q_alu_ctl;
  logic [INT_QUEUE_SIZE-1:0][ADDR_WIDTH-1:0] q_recovery_target;
  logic [INT_QUEUE_SIZE-1:0][ACTIVE_LIST_SIZE_INDEX-1:0] q_active_list_id;
  logic [1:0] alloc_valid, wb_valid;
  logic [1:0][INT_QUEUE_SIZE_INDEX-1:0] alloc_index;
  logic [1:0][PHYS_REG_NUM_INDEX-1:0] wb_tag;
  logic alu_stall, flush;
  logic [INT_QUEUE_SIZE-1:0] clear_mask;
  logic alu_valid, alu_is_branch, alu_prediction, alu_uses_rs, alu_uses_rt, alu_uses_immediate;
  logic [PHYS_REG_NUM_INDEX-1:0] alu_src1, alu_src2;
  logic [DATA_WIDTH-1:0] alu_immediate;
  logic [ALU_CTL_WIDTH-1:0] alu_alu_ctl;
  logic [ADDR_WIDTH-1:0] alu_recovery_target;
  logic [ACTIVE_LIST_SIZE_INDEX-1:0] alu_active_list_id;
  modport master (
    output q_entry_available_bit, q_ready_src1, q_ready_src2, q_is_branch, q_prediction, q_uses_rs,
           q_uses_rt, q_uses_immediate, q_src1, q_src2, q_immediate, q_alu_ctl, q_recovery_target,
           q_active_list_id, alloc_valid, alloc_index, wb_valid, wb_tag, alu_stall, flush,
    input  clear_mask, alu_valid, alu_is_branch, alu_prediction, alu_uses_rs, alu_uses_rt,
           alu_uses_immediate, alu_src1, alu_src2, alu_immediate, alu_alu_ctl, alu_recovery_target,
           alu_active_list_id
  );
  modport slave (
    input  q_entry_available_bit, q_ready_src1, q_ready_src2, q_is_branch, q_prediction, q_uses_rs,
           q_uses_rt, q_uses_immediate, q_src1, q_src2, q_immediate, q_alu_ctl, q_recovery_target,
           q_active_list_id, alloc_valid, alloc_index, wb_valid, wb_tag, alu_stall, flush,
    output clear_mask, alu_valid, alu_is_branch, alu_prediction, alu_uses_rs, alu_uses_rt,
           alu_uses_immediate, alu_src1, alu_src2, alu_immediate, alu_alu_ctl, alu_recovery_target,
           alu_active_list_id
  );
endinterface

// File: rtl/integer_issue_select.sv
// integer_issue_select: oldest-ready pick from the integer issue queue into the ALU issue register.
// INT_SELECT_BYPASS_EN: sources matching a same-cycle write-back tag also count as ready.
module integer_issue_select #(
  parameter int INT_QUEUE_SIZE = 8,
  parameter int INT_QUEUE_SIZE_INDEX = 3,
  parameter int PHYS_REG_NUM_INDEX = 6,
  parameter int ACTIVE_LIST_SIZE_INDEX = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ALU_CTL_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  integer_issue_select_if.slave bus
);
  localparam int N = INT_QUEUE_SIZE;
  typedef struct packed {
    logic [PHYS_REG_NUM_INDEX-1:0] src1, src2;
    logic [DATA_WIDTH-1:0] immediate;
    logic [ALU_CTL_WIDTH-1:0] alu_ctl;
    logic is_branch, prediction;
    logic [ADDR_WIDTH-1:0] recovery_target;
    logic uses_rs, uses_rt, uses_immediate;
    logic [ACTIVE_LIST_SIZE_INDEX-1:0] active_list_id;
  } payload_t;
  logic [N-1:0][N-1:0] older, older_t;
  logic [N-1:0] rdy1, rdy2, req, cand, grant, a0_oh, a1_oh;
  logic [INT_QUEUE_SIZE_INDEX-1:0] gi;
  logic valid, stalled;
  payload_t sel, r;
`ifdef INT_SELECT_BYPASS_EN
  always_comb begin
    rdy1 = bus.q_ready_src1;
    rdy2 = bus.q_ready_src2;
    for (int i = 0; i < N; i++)
      for (int w = 0; w < 2; w++) begin
        rdy1[i] = rdy1[i] | (bus.wb_valid[w] & (bus.wb_tag[w] == bus.q_src1[i]));
        rdy2[i] = rdy2[i] | (bus.wb_valid[w] & (bus.wb_tag[w] == bus.q_src2[i]));
      end
  end
`else
  assign rdy1 = bus.q_ready_src1;
  assign rdy2 = bus.q_ready_src2;
`endif
  assign req = ~bus.q_entry_available_bit & (rdy1 | ~bus.q_uses_rs) & (rdy2 | ~bus.q_uses_rt);
  assign stalled = bus.alu_stall & valid;
  // a requester wins only if no older entry is also requesting
  always_comb begin
    older_t = '0;
    cand = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        older_t[i][j] = older[j][i];
    for (int i = 0; i < N; i++)
      cand[i] = req[i] & ~|(req & older_t[i]);
  end
  // lowest-index pick keeps the grant one-hot for entries left unordered by a flush
  assign grant = (stalled | rst | bus.flush) ? '0 : cand & (~cand + N'(1));
  assign bus.clear_mask = grant;
  always_comb begin
    gi = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) gi = INT_QUEUE_SIZE_INDEX'(i);
  end
  assign sel = {bus.q_src1[gi], bus.q_src2[gi], bus.q_immediate[gi], bus.q_alu_ctl[gi],
                bus.q_is_branch[gi], bus.q_prediction[gi], bus.q_recovery_target[gi],
                bus.q_uses_rs[gi], bus.q_uses_rt[gi], bus.q_uses_immediate[gi], bus.q_active_list_id[gi]};
  assign a0_oh = bus.alloc_valid[0] ? N'(1) << bus.alloc_index[0] : '0;
  assign a1_oh = bus.alloc_valid[1] ? N'(1) << bus.alloc_index[1] : '0;
  // slot 1 is applied last so slot 0's entry ends up older than slot 1's
  always_ff @(posedge clk)
    if (rst || bus.flush) older <= '0;
    else
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (i != j)
            older[i][j] <= a1_oh[i] ? 1'b0 : a1_oh[j] ? 1'b1 : a0_oh[i] ? 1'b0 : a0_oh[j] ? 1'b1 : older[i][j];
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      r <= '0;
    end else if (bus.flush) valid <= 1'b0;
    else if (!stalled) begin
      valid <= |grant;
      if (|grant) r <= sel;
    end
  assign bus.alu_valid = valid;
  assign bus.alu_src1 = r.src1;
  assign bus.alu_src2 = r.src2;
  assign bus.alu_immediate = r.immediate;
  assign bus.alu_alu_ctl = r.alu_ctl;
  assign bus.alu_is_branch = r.is_branch;
  assign bus.alu_prediction = r.prediction;
  assign bus.alu_recovery_target = r.recovery_target;
  assign bus.alu_uses_rs = r.uses_rs;
  assign bus.alu_uses_rt = r.uses_rt;
  assign bus.alu_uses_immediate = r.uses_immediate;
  assign bus.alu_active_list_id = r.active_list_id;
endmodule

// File: tb/tb_integer_issue_select.sv
// tb_integer_issue_select: issue-stage model plus age-ordered scoreboard for integer_issue_select.
module tb_integer_issue_select;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  integer_issue_select_if bus ();
  integer_issue_select dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  int ord[$];
  logic [89:0] sb[$];
  logic [89:0] cur;
  bit m_valid = 0;
  bit rnd_ready = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [89:0] exp_pay(input int k);
    return {bus.q_src1[k], bus.q_src2[k], bus.q_immediate[k], bus.q_alu_ctl[k], bus.q_is_branch[k],
            bus.q_prediction[k], bus.q_recovery_target[k], bus.q_uses_rs[k], bus.q_uses_rt[k],
            bus.q_uses_immediate[k], bus.q_active_list_id[k]};
  endfunction
  function automatic logic [89:0] obs_pay();
    return {bus.alu_src1, bus.alu_src2, bus.alu_immediate, bus.alu_alu_ctl, bus.alu_is_branch,
            bus.alu_prediction, bus.alu_recovery_target, bus.alu_uses_rs, bus.alu_uses_rt,
            bus.alu_uses_immediate, bus.alu_active_list_id};
  endfunction
  function automatic bit req(input int i);
    bit r1, r2;
    r1 = bus.q_ready_src1[i];
    r2 = bus.q_ready_src2[i];
`ifdef INT_SELECT_BYPASS_EN
    for (int w = 0; w < 2; w++) begin
      if (bus.wb_valid[w] && bus.wb_tag[w] == bus.q_src1[i]) r1 = 1;
      if (bus.wb_valid[w] && bus.wb_tag[w] == bus.q_src2[i]) r2 = 1;
    end
`endif
    return !bus.q_entry_available_bit[i] && (r1 || !bus.q_uses_rs[i]) && (r2 || !bus.q_uses_rt[i]);
  endfunction
  task automatic alloc_entry(input int k);
    bus.q_entry_available_bit[k] = 1'b0;
    bus.q_src1[k] = 6'($urandom_range(15));
    bus.q_src2[k] = 6'($urandom_range(15));
    bus.q_immediate[k] = $urandom;
    bus.q_alu_ctl[k] = 4'($urandom);
    bus.q_is_branch[k] = 1'($urandom);
    bus.q_prediction[k] = 1'($urandom);
    bus.q_recovery_target[k] = $urandom;
    bus.q_uses_rs[k] = 1'($urandom);
    bus.q_uses_rt[k] = 1'($urandom);
    bus.q_uses_immediate[k] = 1'($urandom);
    bus.q_active_list_id[k] = 5'($urandom);
    bus.q_ready_src1[k] = rnd_ready ? 1'($urandom) : 1'b1;
    bus.q_ready_src2[k] = rnd_ready ? 1'($urandom) : 1'b1;
    ord.push_back(k);
  endtask
  task automatic cyc(input bit a0, input int k0, input bit a1, input int k1, input bit st, input bit fl,
                     input logic [1:0] wv, input logic [5:0] t0, input logic [5:0] t1);
    int g;
    logic [7:0] em;
    bus.alloc_valid = {a1, a0};
    bus.alloc_index[0] = 3'(k0);
    bus.alloc_index[1] = 3'(k1);
    bus.alu_stall = st;
    bus.flush = fl;
    bus.wb_valid = wv;
    bus.wb_tag[0] = t0;
    bus.wb_tag[1] = t1;
    if (a0) assert (bus.q_entry_available_bit[k0]) else $error("slot0 allocated busy entry %0d", k0);
    if (a1) assert (bus.q_entry_available_bit[k1]) else $error("slot1 allocated busy entry %0d", k1);
    g = -1;
    if (!fl && !(st && m_valid))
      foreach (ord[p]) if (g < 0 && req(ord[p])) g = ord[p];
    em = (g < 0) ? 8'h0 : 8'(1) << g;
    #1 check("clear_mask", bus.clear_mask, em);
    if (g >= 0) sb.push_back(exp_pay(g));
    @(posedge clk);
    #1;
    if (fl) m_valid = 0;
    else if (!(st && m_valid)) begin
      m_valid = g >= 0;
      if (m_valid) cur = sb.pop_front();
    end
    check("alu_valid", bus.alu_valid, m_valid);
    if (m_valid) check("alu_payload", obs_pay(), cur);
    if (g >= 0) begin
      bus.q_entry_available_bit[g] = 1'b1;
      for (int p = 0; p < ord.size(); p++)
        if (ord[p] == g) begin
          ord.delete(p);
          break;
        end
    end
    if (fl) begin
      bus.q_entry_available_bit = '1;
      ord.delete();
    end else begin
      if (a0) alloc_entry(k0);
      if (a1) alloc_entry(k1);
    end
    for (int i = 0; i < N; i++)
      for (int w = 0; w < 2; w++)
        if (wv[w]) begin
          if (bus.q_src1[i] == bus.wb_tag[w]) bus.q_ready_src1[i] = 1'b1;
          if (bus.q_src2[i] == bus.wb_tag[w]) bus.q_ready_src2[i] = 1'b1;
        end
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 6'd0);
  endtask
  task automatic block(input int k);
    bus.q_uses_rs[k] = 1'b1;
    bus.q_ready_src1[k] = 1'b0;
  endtask
  initial begin
    bus.q_entry_available_bit = '1;
    bus.q_ready_src1 = '1;
    bus.q_ready_src2 = '1;
    {bus.q_is_branch, bus.q_prediction, bus.q_uses_rs, bus.q_uses_rt, bus.q_uses_immediate} = '0;
    bus.q_src1 = '0;
    bus.q_src2 = '0;
    bus.q_immediate = '0;
    bus.q_alu_ctl = '0;
    bus.q_recovery_target = '0;
    bus.q_active_list_id = '0;
    bus.alloc_valid = '0;
    bus.alloc_index = '0;
    bus.wb_valid = '0;
    bus.wb_tag = '0;
    bus.alu_stall = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.q_entry_available_bit[0] = 1'b0;
    #1 check("rst_clear_mask", bus.clear_mask, 8'h0);
    check("rst_alu_valid", bus.alu_valid, 1'b0);
    check("rst_payload", obs_pay(), 90'h0);
    @(posedge clk);
    #1 bus.q_entry_available_bit = '1;
    rst = 1'b0;
    // single ready entry: grant next cycle, payload the cycle after
    cyc(1, 3, 0, 0, 0, 0, 2'b00, 6'd0, 6'd0);
    idle();
    idle();
    // 5 allocated before 1, both held back, then released together
    cyc(1, 5, 0, 0, 0, 0, 2'b00, 6'd0, 6'd0);
    block(5);
    cyc(1, 1, 0, 0, 0, 0, 2'b00, 6'd0, 6'd0);
    block(1);
    idle();
    bus.q_ready_src1[5] = 1'b1;
    bus.q_ready_src1[1] = 1'b1;
    idle();
    idle();
    idle();
    // dual alloc: slot0 entry is older
    cyc(1, 6, 1, 2, 0, 0, 2'b00, 6'd0, 6'd0);
    idle();
    idle();
    idle();
    // stall with a valid issue register holds the payload and blocks grants
    cyc(1, 7, 1, 0, 0, 0, 2'b00, 6'd0, 6'd0);
    idle();
    cyc(0, 0, 0, 0, 1, 0, 2'b00, 6'd0, 6'd0);
    cyc(0, 0, 0, 0, 1, 0, 2'b00, 6'd0, 6'd0);
    idle();
    idle();
    // flush beats stall and alloc; later allocs reorder from scratch
    cyc(1, 4, 1, 3, 0, 0, 2'b00, 6'd0, 6'd0);
    idle();
    cyc(1, 5, 0, 0, 1, 1, 2'b00, 6'd0, 6'd0);
    cyc(1, 2, 0, 0, 0, 0, 2'b00, 6'd0, 6'd0);
    block(2);
    cyc(1, 0, 0, 0, 0, 0, 2'b00, 6'd0, 6'd0);
    block(0);
    idle();
    bus.q_ready_src1[2] = 1'b1;
    bus.q_ready_src1[0] = 1'b1;
    idle();
    idle();
    idle();
    // dependent consumer woken by write-back tag 12
    cyc(1, 6, 0, 0, 0, 0, 2'b00, 6'd0, 6'd0);
    block(6);
    bus.q_src1[6] = 6'd12;
    cyc(0, 0, 0, 0, 0, 0, 2'b01, 6'd12, 6'd0);
    idle();
    idle();
    rnd_ready = 1;
    for (int c = 0; c < 80; c++) begin
      int f0, f1;
      f0 = -1;
      f1 = -1;
      for (int t = 0; t < 4; t++) begin
        int k;
        k = $urandom_range(N - 1);
        if (bus.q_entry_available_bit[k]) begin
          if (f0 < 0) f0 = k;
          else if (k != f0) f1 = k;
        end
      end
      cyc(f0 >= 0 && $urandom_range(1) == 1, f0 < 0 ? 0 : f0, f1 >= 0 && $urandom_range(1) == 1, f1 < 0 ? 0 : f1,
          $urandom_range(3) == 0, $urandom_range(15) == 0, 2'($urandom), 6'($urandom_range(15)), 6'($urandom_range(15)));
    end
    rnd_ready = 0;
    cyc(0, 0, 0, 0, 0, 1, 2'b00, 6'd0, 6'd0);
    // reset while stalled drops alu_valid at the next edge
    cyc(1, 1, 1, 4, 0, 0, 2'b00, 6'd0, 6'd0);
    idle();
    bus.alloc_valid = '0;
    bus.alu_stall = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 check("rst_stall_valid", bus.alu_valid, 1'b0);
    check("rst_stall_payload", obs_pay(), 90'h0);
    rst = 1'b0;
    bus.alu_stall = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
